// File: rtl/exc_pkg.sv
// Shared definitions for the exception status writer: exception codes,
// opcode / ALU-op encodings, the $rstatus register index, the mul/div
// FSM state type and an execute-stage decode helper.
package exc_pkg;

  localparam int unsigned STATUS_REG = 30;

  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  typedef enum logic {
    IDLE,
    MD_WAIT
  } md_state_e;

  typedef struct packed {
    logic is_md;
    logic is_setx;
    logic is_bex;
  } x_dec_t;

  // Classify the instruction sitting in X.
  function automatic x_dec_t decode_x(input logic [31:0] inst);
    x_dec_t dec;
    dec.is_md   = (inst[31:27] == OP_ALU) &&
                  ((inst[6:2] == ALU_MUL) || (inst[6:2] == ALU_DIV));
    dec.is_setx = (inst[31:27] == OP_SETX);
    dec.is_bex  = (inst[31:27] == OP_BEX);
    return dec;
  endfunction

endpackage

// File: rtl/exception_status_writer_if.sv
// Bus interface of the exception status writer.
//   slave  : seen by the design (execute/mul-div/writeback inputs,
//            stall/writeback/status outputs)
//   master : seen by the surrounding pipeline or a testbench
interface exception_status_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CODE_W = 3
);
  logic              x_valid;
  logic [31:0]       x_inst;
  logic              x_exc;
  logic [CODE_W-1:0] x_exc_val;
  logic              md_ready;
  logic              md_exc;
  logic [CODE_W-1:0] md_exc_val;
  logic              stall;
  logic              w_we_in;
  logic [4:0]        w_rd_in;
  logic [DATA_W-1:0] w_data_in;
  logic              md_stall;
  logic              w_we;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] rstatus;
  logic              bex_taken;

  modport slave (
    input  x_valid, x_inst, x_exc, x_exc_val,
    input  md_ready, md_exc, md_exc_val, stall,
    input  w_we_in, w_rd_in, w_data_in,
    output md_stall, w_we, w_rd, w_data, rstatus, bex_taken
  );

  modport master (
    output x_valid, x_inst, x_exc, x_exc_val,
    output md_ready, md_exc, md_exc_val, stall,
    output w_we_in, w_rd_in, w_data_in,
    input  md_stall, w_we, w_rd, w_data, rstatus, bex_taken
  );
endinterface

// File: rtl/exc_slot_reg.sv
// One pipeline slot carrying a pending exception: valid, exc flag and the
// word to be written into $rstatus (code zero-extended, or T for setx).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hold         : keep current contents (highest priority)
//   clear        : load an empty slot
//   d_*          : next contents when neither hold nor clear
//   q_*          : registered contents
module exc_slot_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              clear,
  input  logic              d_valid,
  input  logic              d_exc,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic              q_exc,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_d, valid_q;
  logic              exc_d,   exc_q;
  logic [DATA_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    exc_d   = exc_q;
    data_d  = data_q;
    if (!hold) begin
      if (clear) begin
        valid_d = 1'b0;
        exc_d   = 1'b0;
        data_d  = '0;
      end else begin
        valid_d = d_valid;
        exc_d   = d_exc;
        data_d  = d_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      exc_q   <= exc_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_exc   = exc_q;
  assign q_data  = data_q;

endmodule

// File: rtl/exception_status_writer.sv
// Carries execute-stage exceptions through the X/M and M/W slots and, at
// writeback, redirects the register-file write into $rstatus. Holds F/D/X
// while a mul/div is in flight, keeps a shadow copy of $rstatus and
// resolves bex in X with forwarding from the pending slots.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : X-stage instruction + checker results, mul/div result
//                  handshake, external stall, normal writeback in; md_stall,
//                  final writeback, rstatus and bex_taken out
module exception_status_writer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned STATUS_REG = exc_pkg::STATUS_REG
) (
  input  logic                   clock,
  input  logic                   reset,
  exception_status_writer_if.slave bus
);
  import exc_pkg::*;

  localparam logic [4:0] STATUS_RD = 5'(STATUS_REG);

  x_dec_t            dec;
  logic [DATA_W-1:0] setx_t;

  md_state_e         state_d, state_q;
  logic              md_stall_d, md_stall_q;

  logic              xm_hold, xm_clear;
  logic              xm_valid_d, xm_exc_d;
  logic [DATA_W-1:0] xm_data_d;
  logic              xm_valid, xm_exc;
  logic [DATA_W-1:0] xm_data;
  logic              mw_valid, mw_exc;
  logic [DATA_W-1:0] mw_data;

  logic [DATA_W-1:0] rstatus_d, rstatus_q;
  logic [DATA_W-1:0] status_fwd;

  always_comb begin
    dec    = decode_x(bus.x_inst);
    setx_t = DATA_W'(bus.x_inst[26:0]);
  end

  // FSM next state and X/M slot load. In MD_WAIT the X/M slot is always
  // empty (the mul/div itself never enters it), so the result is captured
  // even when stall is asserted on the md_ready cycle.
  always_comb begin
    state_d    = state_q;
    xm_hold    = 1'b0;
    xm_clear   = 1'b1;
    xm_valid_d = 1'b0;
    xm_exc_d   = 1'b0;
    xm_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.stall) begin
          xm_hold = 1'b1;
        end else if (bus.x_valid) begin
          if (dec.is_md) begin
            state_d = MD_WAIT;
          end else begin
            xm_clear   = 1'b0;
            xm_valid_d = 1'b1;
            if (dec.is_setx) begin
              xm_exc_d  = 1'b1;
              xm_data_d = setx_t;
            end else begin
              xm_exc_d  = bus.x_exc;
              xm_data_d = bus.x_exc ? DATA_W'(bus.x_exc_val) : '0;
            end
          end
        end
      end
      MD_WAIT: begin
        if (bus.md_ready) begin
          state_d    = IDLE;
          xm_clear   = 1'b0;
          xm_valid_d = 1'b1;
          xm_exc_d   = bus.md_exc;
          xm_data_d  = bus.md_exc ? DATA_W'(bus.md_exc_val) : '0;
        end else if (bus.stall) begin
          xm_hold = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    md_stall_d = (state_d == MD_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      md_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_stall_q <= md_stall_d;
    end
  end

  exc_slot_reg #(.DATA_W(DATA_W)) u_xm_slot (
    .clock   (clock),
    .reset   (reset),
    .hold    (xm_hold),
    .clear   (xm_clear),
    .d_valid (xm_valid_d),
    .d_exc   (xm_exc_d),
    .d_data  (xm_data_d),
    .q_valid (xm_valid),
    .q_exc   (xm_exc),
    .q_data  (xm_data)
  );

  exc_slot_reg #(.DATA_W(DATA_W)) u_mw_slot (
    .clock   (clock),
    .reset   (reset),
    .hold    (bus.stall),
    .clear   (1'b0),
    .d_valid (xm_valid),
    .d_exc   (xm_exc),
    .d_data  (xm_data),
    .q_valid (mw_valid),
    .q_exc   (mw_exc),
    .q_data  (mw_data)
  );

  // Writeback override: a pending exception replaces the instruction's own
  // write (its overflowed result is dropped).
  always_comb begin
    if (mw_valid && mw_exc) begin
      bus.w_we   = 1'b1;
      bus.w_rd   = STATUS_RD;
      bus.w_data = mw_data;
    end else begin
      bus.w_we   = bus.w_we_in;
      bus.w_rd   = bus.w_rd_in;
      bus.w_data = bus.w_data_in;
    end
  end

  always_comb begin
    rstatus_d = rstatus_q;
    if (bus.w_we && (bus.w_rd == STATUS_RD)) begin
      rstatus_d = bus.w_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstatus_q <= '0;
    end else begin
      rstatus_q <= rstatus_d;
    end
  end

  // Youngest pending status value wins; plain r30 writes in flight are
  // handled by the core's regular bypass network.
  always_comb begin
    if (xm_valid && xm_exc) begin
      status_fwd = xm_data;
    end else if (mw_valid && mw_exc) begin
      status_fwd = mw_data;
    end else begin
      status_fwd = rstatus_q;
    end
  end

  assign bus.md_stall  = md_stall_q;
  assign bus.rstatus   = rstatus_q;
  assign bus.bex_taken = (status_fwd != '0) && bus.x_valid && dec.is_bex;

endmodule

// File: tb/tb_exception_status_writer.sv
module tb_exception_status_writer;
  import exc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exception_status_writer_if #(.DATA_W(32), .CODE_W(3)) bus ();

  exception_status_writer #(
    .DATA_W     (32),
    .CODE_W     (3),
    .STATUS_REG (30)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        xv;
    logic [31:0] inst;
    logic        xexc;
    logic [2:0]  xval;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        e_ms;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_rs;
    logic        e_bex;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] alu_inst(input logic [4:0] op);
    return {OP_ALU, 20'h0, 2'b00, op, 2'b00};
  endfunction
  function automatic logic [31:0] setx_inst(input logic [26:0] t);
    return {OP_SETX, t};
  endfunction
  function automatic logic [31:0] bex_inst();
    return {OP_BEX, 27'h0};
  endfunction
  function automatic logic [31:0] addi_inst();
    return {OP_ADDI, 5'd7, 5'd0, 17'd42};
  endfunction

  task automatic add(input logic xv, input logic [31:0] inst, input logic xexc,
                     input logic [2:0] xval, input logic wwe, input logic [4:0] wrd,
                     input logic [31:0] wdata, input logic e_ms, input logic e_we,
                     input logic [4:0] e_rd, input logic [31:0] e_data,
                     input logic [31:0] e_rs, input logic e_bex);
    vec_t v;
    v.xv = xv; v.inst = inst; v.xexc = xexc; v.xval = xval;
    v.wwe = wwe; v.wrd = wrd; v.wdata = wdata;
    v.e_ms = e_ms; v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
    v.e_rs = e_rs; v.e_bex = e_bex;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.x_valid    = 1'b0;
    bus.x_inst     = '0;
    bus.x_exc      = 1'b0;
    bus.x_exc_val  = '0;
    bus.md_ready   = 1'b0;
    bus.md_exc     = 1'b0;
    bus.md_exc_val = '0;
    bus.stall      = 1'b0;
    bus.w_we_in    = 1'b0;
    bus.w_rd_in    = '0;
    bus.w_data_in  = '0;
  endtask

  // Inputs change right after a falling edge; outputs are sampled 2ns later,
  // well before the next rising edge.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  initial begin
    vec_t v;
    int   hi;
    int   ovr;

    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state: no stall, rstatus clear, writeback passes straight through.
    bus.w_we_in = 1'b1; bus.w_rd_in = 5'd9; bus.w_data_in = 32'hABC;
    #2;
    check("rst md_stall", bus.md_stall, 0);
    check("rst rstatus",  bus.rstatus, 0);
    check("rst w_we",     bus.w_we, 1);
    check("rst w_rd",     bus.w_rd, 9);
    check("rst w_data",   bus.w_data, 32'hABC);
    next_cycle();
    idle_inputs();

    //  xv inst            xexc xval      wwe wrd wdata       ms we rd  data       rs       bex
    add(1, alu_inst(0),     1, EXC_ADD,   0,  0,  0,          0, 0, 0,  0,         0,       0); // add ovf
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         0,       0);
    add(0, 0,               0, 0,         1,  5,  32'hDEAD,   0, 1, 30, 1,         0,       0); // override r5
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         1,       0);
    add(1, addi_inst(),     0, 0,         0,  0,  0,          0, 0, 0,  0,         1,       0); // addi ok
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         1,       0);
    add(0, 0,               0, 0,         1,  7,  42,         0, 1, 7,  42,        1,       0);
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         1,       0);
    add(0, 0,               0, 0,         1,  30, 0,          0, 1, 30, 0,         1,       0); // plain r30 write
    add(0, 0,               0, 0,         1,  0,  32'h77,     0, 1, 0,  32'h77,    0,       0); // rd=0
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         0,       0);
    add(1, setx_inst(27'h1234), 0, 0,     0,  0,  0,          0, 0, 0,  0,         0,       0);
    add(1, bex_inst(),      0, 0,         0,  0,  0,          0, 0, 0,  0,         0,       1); // X/M fwd
    add(0, 0,               0, 0,         0,  0,  0,          0, 1, 30, 32'h1234,  0,       0);
    add(1, setx_inst(27'h0), 0, 0,        0,  0,  0,          0, 0, 0,  0,         32'h1234,0);
    add(1, bex_inst(),      0, 0,         0,  0,  0,          0, 0, 0,  0,         32'h1234,0); // fwd of 0
    add(0, 0,               0, 0,         0,  0,  0,          0, 1, 30, 0,         32'h1234,0);
    add(1, setx_inst(27'h7), 0, 0,        0,  0,  0,          0, 0, 0,  0,         0,       0);
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         0,       0);
    add(1, bex_inst(),      0, 0,         0,  0,  0,          0, 1, 30, 7,         0,       1); // M/W fwd
    add(1, bex_inst(),      0, 0,         0,  0,  0,          0, 0, 0,  0,         7,       1); // rstatus
    add(0, bex_inst(),      0, 0,         0,  0,  0,          0, 0, 0,  0,         7,       0); // not valid
    add(1, alu_inst(1),     1, EXC_SUB,   0,  0,  0,          0, 0, 0,  0,         7,       0); // back-to-back
    add(1, alu_inst(0),     1, EXC_ADD,   0,  0,  0,          0, 0, 0,  0,         7,       0);
    add(0, 0,               0, 0,         0,  0,  0,          0, 1, 30, 3,         7,       0);
    add(0, 0,               0, 0,         0,  0,  0,          0, 1, 30, 1,         3,       0);
    add(0, 0,               0, 0,         0,  0,  0,          0, 0, 0,  0,         1,       0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      bus.x_valid   = v.xv;
      bus.x_inst    = v.inst;
      bus.x_exc     = v.xexc;
      bus.x_exc_val = v.xval;
      bus.w_we_in   = v.wwe;
      bus.w_rd_in   = v.wrd;
      bus.w_data_in = v.wdata;
      #2;
      check($sformatf("row%0d md_stall", i),  bus.md_stall,  v.e_ms);
      check($sformatf("row%0d w_we", i),      bus.w_we,      v.e_we);
      check($sformatf("row%0d w_rd", i),      bus.w_rd,      v.e_rd);
      check($sformatf("row%0d w_data", i),    bus.w_data,    v.e_data);
      check($sformatf("row%0d rstatus", i),   bus.rstatus,   v.e_rs);
      check($sformatf("row%0d bex_taken", i), bus.bex_taken, v.e_bex);
      next_cycle();
    end
    idle_inputs();

    // div: md_ready on the 33rd cycle after issue, md_stall high throughout.
    bus.x_valid = 1'b1; bus.x_inst = alu_inst(ALU_DIV);
    #2;
    check("div issue md_stall", bus.md_stall, 0);
    next_cycle();
    hi = 0;
    for (int i = 0; i < 33; i++) begin
      bus.md_ready   = (i == 32);
      bus.md_exc     = (i == 32);
      bus.md_exc_val = (i == 32) ? EXC_DIV : 3'd0;
      #2;
      if (bus.md_stall) hi++;
      next_cycle();
    end
    check("div md_stall cycles", hi, 33);
    idle_inputs();
    #2;
    check("div release md_stall", bus.md_stall, 0);
    check("div slot1 w_we", bus.w_we, 0);
    next_cycle();
    #2;
    check("div wb w_we", bus.w_we, 1);
    check("div wb w_rd", bus.w_rd, 30);
    check("div wb w_data", bus.w_data, EXC_DIV);
    next_cycle();
    #2;
    check("div rstatus", bus.rstatus, 5);
    check("div after w_we", bus.w_we, 0);

    // Stall for 3 cycles with a sub exception parked in X/M.
    bus.x_valid = 1'b1; bus.x_inst = alu_inst(1); bus.x_exc = 1'b1; bus.x_exc_val = EXC_SUB;
    next_cycle();
    idle_inputs();
    ovr = 0;
    for (int i = 0; i < 6; i++) begin
      bus.stall = (i < 3);
      #2;
      if (bus.w_we) begin
        ovr++;
        check($sformatf("stall ovr%0d cycle", ovr), i, 4);
        check("stall ovr w_rd", bus.w_rd, 30);
        check("stall ovr w_data", bus.w_data, EXC_SUB);
      end
      if (i < 5) check($sformatf("stall c%0d rstatus", i), bus.rstatus, 5);
      next_cycle();
    end
    check("stall override count", ovr, 1);
    #2;
    check("stall rstatus", bus.rstatus, 3);

    // exc=1 with code 0 is written as given.
    bus.x_valid = 1'b1; bus.x_inst = alu_inst(0); bus.x_exc = 1'b1; bus.x_exc_val = 3'd0;
    next_cycle();
    idle_inputs();
    next_cycle();
    #2;
    check("code0 w_we", bus.w_we, 1);
    check("code0 w_rd", bus.w_rd, 30);
    check("code0 w_data", bus.w_data, 0);
    next_cycle();
    #2;
    check("code0 rstatus", bus.rstatus, 0);

    // stall and md_ready together: mul result still captured.
    bus.x_valid = 1'b1; bus.x_inst = alu_inst(ALU_MUL);
    #2;
    check("mul issue md_stall", bus.md_stall, 0);
    next_cycle();
    #2;
    check("mul wait md_stall", bus.md_stall, 1);
    next_cycle();
    bus.stall = 1'b1; bus.md_ready = 1'b1; bus.md_exc = 1'b1; bus.md_exc_val = EXC_MUL;
    #2;
    check("mul ready md_stall", bus.md_stall, 1);
    next_cycle();
    idle_inputs();
    #2;
    check("mul done md_stall", bus.md_stall, 0);
    check("mul slot1 w_we", bus.w_we, 0);
    next_cycle();
    #2;
    check("mul wb w_we", bus.w_we, 1);
    check("mul wb w_rd", bus.w_rd, 30);
    check("mul wb w_data", bus.w_data, EXC_MUL);
    next_cycle();
    #2;
    check("mul rstatus", bus.rstatus, 4);

    // md_ready while IDLE is ignored.
    bus.md_ready = 1'b1; bus.md_exc = 1'b1; bus.md_exc_val = EXC_DIV;
    next_cycle();
    idle_inputs();
    #2;
    check("idle md_ready md_stall", bus.md_stall, 0);
    next_cycle();
    #2;
    check("idle md_ready w_we", bus.w_we, 0);
    next_cycle();
    #2;
    check("idle md_ready rstatus", bus.rstatus, 4);

    // Reset during MD_WAIT drops the pending result.
    bus.x_valid = 1'b1; bus.x_inst = alu_inst(ALU_DIV);
    next_cycle();
    idle_inputs();
    #2;
    check("rst6 pre md_stall", bus.md_stall, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.md_ready = 1'b1; bus.md_exc = 1'b1; bus.md_exc_val = EXC_DIV;
    #2;
    check("rst6 md_stall", bus.md_stall, 0);
    check("rst6 rstatus", bus.rstatus, 0);
    next_cycle();
    idle_inputs();
    #2;
    check("rst6 c1 w_we", bus.w_we, 0);
    next_cycle();
    #2;
    check("rst6 c2 w_we", bus.w_we, 0);
    check("rst6 c2 md_stall", bus.md_stall, 0);
    next_cycle();
    #2;
    check("rst6 c3 rstatus", bus.rstatus, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
